pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 14 +
 rtl/pc_redirect_hold.sv | 52 +++++
 rtl/pc_unit.sv | 81 ++++++++
 tb/tb_pc_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding and
// the default parameter values used by pc_unit and its redirect holder.
package pc_unit_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

  localparam int          PC_XLEN_DEFAULT         = 32;
  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          PC_INST_BYTES_DEFAULT   = 4;

endpackage : pc_unit_pkg

// File: rtl/pc_redirect_hold.sv
// Redirect target alignment, the pending-target register held across an
// instruction-memory stall, and the registered misalignment pulse.
module pc_redirect_hold
  import pc_unit_pkg::*;
#(
  parameter int XLEN       = PC_XLEN_DEFAULT,
  parameter int INST_BYTES = PC_INST_BYTES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic            busywait,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] aligned_target,
  output logic [XLEN-1:0] pending_target,
  output logic            misalign
);

  localparam int              LOW_BITS = (INST_BYTES == 4) ? 2 : 1;
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((1 << LOW_BITS) - 1);

  logic [XLEN-1:0] pending_target_d, pending_target_q;
  logic            misalign_d, misalign_q;

  assign aligned_target = redirect_target & ~LOW_MASK;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pending_target_d = pending_target_q;
    misalign_d       = 1'b0;
    // Any redirect seen is either applied now or captured; both count for misalign.
    if (redirect_valid) begin
      misalign_d = |(redirect_target & LOW_MASK);
      if (busywait) pending_target_d = aligned_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_target_q <= '0;
      misalign_q       <= 1'b0;
    end else begin
      pending_target_q <= pending_target_d;
      misalign_q       <= misalign_d;
    end
  end

  assign pending_target = pending_target_q;
  assign misalign       = misalign_q;

endmodule : pc_redirect_hold

// File: rtl/pc_unit.sv
// Fetch program counter: sequential increment, stall handling and branch
// redirects that are held while instruction memory is busy.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
  parameter int              INST_BYTES   = PC_INST_BYTES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            busywait,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            redirect_pending,
  output logic            misalign
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(INST_BYTES);

  pc_state_e       state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] aligned_target;
  logic [XLEN-1:0] pending_target;

  pc_redirect_hold #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_redirect_hold (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .busywait        (busywait),
    .redirect_target (redirect_target),
    .aligned_target  (aligned_target),
    .pending_target  (pending_target),
    .misalign        (misalign)
  );

  assign pc_next_seq = pc_q + PC_INC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      RUN: begin
        // Redirect outranks stall; only busywait can defer it.
        if (redirect_valid) begin
          if (busywait) state_d = HOLD;
          else          pc_d    = aligned_target;
        end else if (!busywait && !stall) begin
          pc_d = pc_next_seq;
        end
      end
      HOLD: begin
        if (!busywait) begin
          pc_d    = redirect_valid ? aligned_target : pending_target;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_out           = pc_q;
  assign redirect_pending = (state_q == HOLD);

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busywait = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc_out;
  logic [31:0] pc_next_seq;
  logic        redirect_pending;
  logic        misalign;

  int passed = 0;
  int total  = 0;

  // Behavioural model state: architectural PC, whether a redirect is parked,
  // the parked (aligned) address and the expected misalign flag.
  logic [31:0] m_pc   = 32'h0;
  bit          m_hold = 1'b0;
  logic [31:0] m_pend = 32'h0;
  bit          m_mis  = 1'b0;

  pc_unit dut (
    .clk              (clk),
    .rst              (rst),
    .busywait         (busywait),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .pc_out           (pc_out),
    .pc_next_seq      (pc_next_seq),
    .redirect_pending (redirect_pending),
    .misalign         (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    logic [31:0] tgt;
    tgt = redirect_target & ~32'h3;
    if (rst) begin
      m_pc = 32'h0; m_hold = 0; m_pend = 32'h0; m_mis = 0;
    end else begin
      m_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
      if (!m_hold) begin
        if (redirect_valid) begin
          if (busywait) begin m_pend = tgt; m_hold = 1; end
          else m_pc = tgt;
        end else if (!busywait && !stall) begin
          m_pc = m_pc + 32'd4;
        end
      end else begin
        if (redirect_valid) m_pend = tgt;
        if (!busywait) begin m_pc = m_pend; m_hold = 0; end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic step(input bit r, input bit bw, input bit st, input bit rv, input logic [31:0] t);
    rst = r; busywait = bw; stall = st; redirect_valid = rv; redirect_target = t;
    @(posedge clk);
    model_edge();
    #1;
    check("pc_out", pc_out, m_pc);
    check("pc_next_seq", pc_next_seq, m_pc + 32'd4);
    check("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_hold});
    check("misalign", {31'b0, misalign}, {31'b0, m_mis});
  endtask

  initial begin
    @(posedge clk); #1;

    // Reset then free-run.
    step(1, 0, 0, 0, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_pending", {31'b0, redirect_pending}, 32'h0);
    step(0, 0, 0, 0, 32'h0); check("free_4", pc_out, 32'h4);
    step(0, 0, 0, 0, 32'h0); check("free_8", pc_out, 32'h8);
    step(0, 0, 0, 0, 32'h0); check("free_c", pc_out, 32'hC);
    step(0, 0, 0, 0, 32'h0); check("free_10", pc_out, 32'h10);

    // Redirect under busywait is held until memory is ready.
    step(0, 1, 0, 1, 32'h200);
    check("hold_pc_a", pc_out, 32'h10);
    check("hold_pend_a", {31'b0, redirect_pending}, 32'h1);
    step(0, 1, 0, 0, 32'h0);
    check("hold_pc_b", pc_out, 32'h10);
    step(0, 0, 0, 0, 32'h0);
    check("hold_apply", pc_out, 32'h200);
    check("hold_clear", {31'b0, redirect_pending}, 32'h0);

    // Redirect beats stall; stall alone holds.
    step(0, 0, 1, 1, 32'h80); check("stall_redir", pc_out, 32'h80);
    step(0, 0, 1, 0, 32'h0);  check("stall_hold", pc_out, 32'h80);

    // Newest pending redirect wins; stall ignored in HOLD.
    step(0, 1, 0, 1, 32'h200);
    step(0, 1, 1, 1, 32'h300);
    step(0, 0, 1, 0, 32'h0);
    check("newest_wins", pc_out, 32'h300);

    // Misaligned target is aligned and flagged for one cycle.
    step(0, 0, 0, 1, 32'h103);
    check("mis_pc", pc_out, 32'h100);
    check("mis_pulse", {31'b0, misalign}, 32'h1);
    step(0, 0, 0, 0, 32'h0);
    check("mis_drop", {31'b0, misalign}, 32'h0);
    check("mis_next", pc_out, 32'h104);

    // Wrap at the top of the address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_pre", pc_out, 32'hFFFF_FFFC);
    check("wrap_seq", pc_next_seq, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check("wrap_zero", pc_out, 32'h0);

    // Reset while holding discards the pending redirect.
    step(0, 1, 0, 1, 32'h400);
    check("pre_rst_hold", {31'b0, redirect_pending}, 32'h1);
    step(1, 1, 0, 0, 32'h0);
    check("rst_hold_pc", pc_out, 32'h0);
    check("rst_hold_pend", {31'b0, redirect_pending}, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check("no_stale", pc_out, 32'h4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_pc_unit
